seq_tx_serializer: RTL

//  Transmit side of the serial bit-stream link that feeds the sequence detectors
//  (seq_det_101_mealy / seq_det_101_moore). Accepts a parallel word plus a bit

---
 rtl/seq_pkg.sv | 20 ++
 rtl/seq_tx_shreg.sv | 42 ++++
 rtl/seq_tx_serializer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// seq_pkg
//   Shared definitions for the serial bit-stream link: transmitter state
//   encodings and the default word geometry used by the serializer and by
//   the detector benches.
package seq_pkg;

  // Default word geometry shared with the detector side.
  localparam int SEQ_WIDTH      = 15;
  localparam int SEQ_CNT_W      = 4;
  localparam int SEQ_GAP_CYCLES = 2;

  // Transmitter state encodings. The values are fixed so that debug taps
  // and external checkers can decode the state without this package.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10
  } tx_state_e;

endpackage

// File: rtl/seq_tx_shreg.sv
// seq_tx_shreg
//   WIDTH-bit loadable left-shift register. The MSB is the bit currently on
//   the line; each shift brings the next bit up and fills the LSB with 0.
// Ports
//   clk        in  rising-edge clock
//   clr_i      in  synchronous clear (highest priority)
//   load_i     in  load load_val_i (beats shift_i)
//   shift_i    in  shift left by one
//   load_val_i in  WIDTH-bit value to load
//   msb_o      out current MSB
module seq_tx_shreg #(
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (load_i) begin
      q_d = load_val_i;
    end else if (shift_i) begin
      q_d = {q_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign msb_o = q_q[WIDTH-1];

endmodule

// File: rtl/seq_tx_serializer.sv
// seq_tx_serializer
//   Transmit side of the serial link feeding the 101 sequence detectors.
//   Accepts a word plus bit length over a valid/ready handshake and shifts
//   bits [len-1:0] out MSB-first on x, one per clock, with x_valid marking
//   live bits. An optional idle gap of GAP_CYCLES follows each word.
// Ports
//   clk        in  rising-edge clock
//   rst        in  synchronous active-high reset
//   load_valid in  load_data/load_len valid
//   load_ready out serializer accepts a word this cycle
//   load_data  in  word; load_data[len-1] is sent first
//   load_len   in  bit count; 0 or >WIDTH means WIDTH
//   x          out serial data, 0 whenever x_valid is low
//   x_valid    out x carries a live bit
//   busy       out state is not IDLE
//   done       out one-cycle registered pulse after the last bit of a word
//   state_dbg  out current FSM state (seq_pkg::tx_state_e encoding)
//
// Handshake: a word transfers on a rising edge where load_valid and
// load_ready are both high. load_ready never depends on load_valid; a source
// seeing load_ready low must hold load_valid and its data until accepted.
module seq_tx_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH      = SEQ_WIDTH,
  parameter int CNT_W      = SEQ_CNT_W,
  parameter int GAP_CYCLES = SEQ_GAP_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] load_len,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  tx_state_e        state_q;
  logic [CNT_W-1:0] rem_q;
  logic [GAP_W-1:0] gap_q;
  logic             done_q;

  logic [CNT_W-1:0] eff_len;
  logic [WIDTH-1:0] load_val;
  logic             accept;
  logic             last_bit;
  logic             in_shift;
  logic             shreg_msb;

  // Out-of-range lengths fall back to a full word.
  always_comb begin
    eff_len = load_len;
    if (load_len == '0 || int'(load_len) > WIDTH) begin
      eff_len = CNT_W'(WIDTH);
    end
  end

  // Left-justify the word so its first bit sits in the MSB.
  assign load_val = load_data << (WIDTH - int'(eff_len));

  assign in_shift = (state_q == ST_SHIFT);
  assign last_bit = in_shift && (rem_q == CNT_W'(1));

  // Without a gap the next word may be taken during the last bit, so the
  // line carries words back to back with no bubble.
  assign load_ready = !rst && ((state_q == ST_IDLE) ||
                               ((GAP_CYCLES == 0) && last_bit));
  assign accept     = load_valid && load_ready;

  seq_tx_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk       (clk),
    .clr_i     (rst),
    .load_i    (accept),
    .shift_i   (in_shift && !accept),
    .load_val_i(load_val),
    .msb_o     (shreg_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_SHIFT;
            rem_q   <= eff_len;
          end
        end
        ST_SHIFT: begin
          rem_q <= rem_q - CNT_W'(1);
          if (last_bit) begin
            done_q <= 1'b1;
            if (accept) begin
              state_q <= ST_SHIFT;
              rem_q   <= eff_len;
            end else if (GAP_CYCLES > 0) begin
              state_q <= ST_GAP;
              gap_q   <= GAP_W'(GAP_CYCLES);
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          gap_q <= gap_q - GAP_W'(1);
          if (gap_q <= GAP_W'(1)) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are gated by rst so the line is quiet during reset, and x is
  // forced low outside SHIFT so the detector never sees stale bits.
  assign x_valid   = !rst && in_shift;
  assign x         = x_valid && shreg_msb;
  assign busy      = !rst && (state_q != ST_IDLE);
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule
